slice_pair_feeder: RTL

Buffers one full 5x5x64 state arriving as a stream of 64 slices of 25 bits, then replays it as (previous slice, current slice) pairs to the column-parity stage. Slice 0's predecessor is slice 63, so the whole state is captured before emission starts. The block sits directly upstream of `colParity`: `out_prev` drives its `input1` and `out_cur` drives its `input2`. It also supplies the slice index and last-slice flag that downstream stages need.

---
 rtl/matrix_enc_pkg.sv | 26 ++
 rtl/slice_pair_feeder_if.sv | 29 ++
 rtl/slice_store.sv | 31 +++
 rtl/slice_pair_feeder.sv | 107 ++++++++++
 4 files changed

// File: rtl/matrix_enc_pkg.sv
// Shared types and sizes for the slice-stream front end of the matrix encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_enc_pkg;

    localparam int SLICE_W    = 25;
    localparam int NUM_SLICES = 64;
    localparam int IDX_W      = $clog2(NUM_SLICES);

    typedef logic [SLICE_W-1:0] slice_t;
    typedef logic [IDX_W-1:0]   slice_idx_t;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } feeder_state_e;

    localparam slice_idx_t LAST_IDX = slice_idx_t'(NUM_SLICES - 1);

    // Predecessor index. NUM_SLICES is a power of two, so the natural
    // wrap of the index width gives the modulo: 0 -> NUM_SLICES-1.
    function automatic slice_idx_t prev_idx(input slice_idx_t idx);
        return idx - slice_idx_t'(1);
    endfunction

endpackage

// File: rtl/slice_pair_feeder_if.sv
// Bundles the slice input stream and the (prev, cur) pair output stream.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Ports: master = slice producer / pair consumer, slave = the feeder.
interface slice_pair_feeder_if;
    import matrix_enc_pkg::*;

    logic       in_valid;
    logic       in_ready;
    slice_t     in_slice;
    logic       out_valid;
    logic       out_ready;
    slice_t     out_prev;
    slice_t     out_cur;
    slice_idx_t out_idx;
    logic       out_last;
    logic       frame_done;

    modport master (
        output in_valid, in_slice, out_ready,
        input  in_ready, out_valid, out_prev, out_cur, out_idx, out_last, frame_done
    );

    modport slave (
        input  in_valid, in_slice, out_ready,
        output in_ready, out_valid, out_prev, out_cur, out_idx, out_last, frame_done
    );

endinterface

// File: rtl/slice_store.sv
// NUM_SLICES x SLICE_W register array holding one full state.
// Latency: write lands on the next edge; both reads are combinational.
// Backpressure: none; the caller gates wr_en_i.
// Ports: clk; write port (wr_en_i, wr_idx_i, wr_dat_i); read ports cur and prev.
module slice_store
    import matrix_enc_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en_i,
    input  slice_idx_t wr_idx_i,
    input  slice_t     wr_dat_i,
    input  slice_idx_t cur_idx_i,
    output slice_t     cur_dat_o,
    input  slice_idx_t prev_idx_i,
    output slice_t     prev_dat_o
);

    // No reset: stale contents are never shown because a frame is only
    // emitted after all NUM_SLICES entries have been rewritten.
    slice_t mem_q [NUM_SLICES];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_dat_i;
        end
    end

    assign cur_dat_o  = mem_q[cur_idx_i];
    assign prev_dat_o = mem_q[prev_idx_i];

endmodule

// File: rtl/slice_pair_feeder.sv
// Captures a full 64-slice state, then replays it as (slice k-1, slice k) pairs.
// Latency: first pair valid the cycle after the 64th accepted slice; frame period >= 128 cycles.
// Backpressure: in_ready low while emitting; pairs held stable while out_ready is low.
// Ports: clk, rst (sync, active-high); bus = slave side of slice_pair_feeder_if.
module slice_pair_feeder
    import matrix_enc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    slice_pair_feeder_if.slave bus
);

    feeder_state_e state_q, state_d;
    slice_idx_t    wr_idx_q, wr_idx_d;
    slice_idx_t    rd_idx_q, rd_idx_d;
    logic          frame_done_q, frame_done_d;

    logic   load_rdy;
    logic   emit_vld;
    logic   in_fire;
    logic   out_fire;
    slice_t cur_dat;
    slice_t prev_dat;

    // Handshake qualifiers come from state (and rst) only, never from the
    // partner's valid/ready, so there is no combinational loop across the bus.
    assign load_rdy = (state_q == LOAD) && !rst;
    assign emit_vld = (state_q == EMIT) && !rst;
    assign in_fire  = bus.in_valid && load_rdy;
    assign out_fire = emit_vld && bus.out_ready;

    slice_store u_store (
        .clk       (clk),
        .wr_en_i   (in_fire),
        .wr_idx_i  (wr_idx_q),
        .wr_dat_i  (bus.in_slice),
        .cur_idx_i (rd_idx_q),
        .cur_dat_o (cur_dat),
        .prev_idx_i(prev_idx(rd_idx_q)),
        .prev_dat_o(prev_dat)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        frame_done_d = 1'b0;
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    if (wr_idx_q == LAST_IDX) begin
                        state_d  = EMIT;
                        wr_idx_d = '0;
                        rd_idx_d = '0;
                    end else begin
                        wr_idx_d = wr_idx_q + slice_idx_t'(1);
                    end
                end
            end
            EMIT: begin
                if (out_fire) begin
                    if (rd_idx_q == LAST_IDX) begin
                        state_d      = LOAD;
                        rd_idx_d     = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        rd_idx_d = rd_idx_q + slice_idx_t'(1);
                    end
                end
            end
        endcase
    end

    // Outputs: data is forced to zero whenever no pair is presented.
    always_comb begin
        bus.in_ready   = load_rdy;
        bus.out_valid  = emit_vld;
        bus.out_prev   = '0;
        bus.out_cur    = '0;
        bus.out_idx    = '0;
        bus.out_last   = 1'b0;
        bus.frame_done = frame_done_q;
        if (emit_vld) begin
            bus.out_prev = prev_dat;
            bus.out_cur  = cur_dat;
            bus.out_idx  = rd_idx_q;
            bus.out_last = (rd_idx_q == LAST_IDX);
        end
    end

endmodule
